// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear stopwatch built on an NDIG-digit BCD
// decade chain. A timebase tick is gated into the chain while in RUN; the
// carry ripples combinationally so all affected digits update on one edge.
//
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the displayed count).
//
// Parameters:
//   NDIG  number of BCD digits (1..8), digit 0 least significant
//   WRAP  1 = roll over all-9s to all-0s, 0 = saturate and halt
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   tick        timebase enable pulse, one count per pulse
//   start_stop  run/pause toggle pulse
//   clear       zero the count and return to idle
//   lap         display freeze toggle (used only with STOPWATCH_LAP_EN)
//   bcd_out     displayed count, digit i at [4i+3:4i]
//   running     high in RUN
//   paused      high in PAUSE
//   ovf         overflow indication
module bcd_stopwatch_ctrl #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned WRAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                running,
  output logic                paused,
  output logic                ovf
);

  localparam int unsigned CW = 4 * NDIG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   bcd_q;
  logic            running_q;
  logic            paused_q;
  logic            ovf_q;
  logic            count_en;
  logic            ovf_evt;
  logic            frz_q;
  logic            frz_d;

  // Decade chain: digit i advances when all lower digits are 9.
  always_comb begin
    logic       carry;
    logic       all9;
    logic [3:0] dig;
    cnt_d    = cnt_q;
    count_en = (state_q == S_RUN) && tick;
    carry    = count_en;
    all9     = 1'b1;
    dig      = 4'd0;
    for (int i = 0; i < int'(NDIG); i++) begin
      dig = cnt_q[4*i +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      // Codes 9..15 all load 0, so illegal codes self-recover.
      if (carry) cnt_d[4*i +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
      carry = carry && (dig == 4'd9);
    end
    ovf_evt = count_en && all9;
    // Saturating build holds all-9s instead of wrapping.
    if (ovf_evt && (WRAP == 0)) cnt_d = cnt_q;
  end

`ifdef STOPWATCH_LAP_EN
  // Freeze latch: set by lap in RUN, released by lap in RUN or PAUSE.
  always_comb begin
    frz_d = frz_q;
    if (lap) begin
      if (frz_q && (state_q == S_RUN || state_q == S_PAUSE)) frz_d = 1'b0;
      else if (!frz_q && state_q == S_RUN)                  frz_d = 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign frz_d      = 1'b0;
`endif

  // State machine, count and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      ovf_q     <= 1'b0;
      frz_q     <= 1'b0;
    end else if (clear) begin
      // clear wins over start_stop and discards a coincident tick
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      ovf_q     <= 1'b0;
      frz_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      frz_q <= frz_d;
      // Frozen display holds its captured value; otherwise it tracks the count.
      if (!frz_d) bcd_q <= cnt_d;
      ovf_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_stop) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (ovf_evt && (WRAP == 0)) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
            ovf_q     <= 1'b1;
          end else begin
            if (ovf_evt) ovf_q <= 1'b1;
            if (start_stop) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (start_stop) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        S_HALT: begin
          ovf_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out = bcd_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: a wrapping and a saturating
// instance share one stimulus stream; expected values are hand-computed.
module tb_bcd_stopwatch_ctrl;

  localparam int unsigned NDIG = 4;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic [4*NDIG-1:0] bcd_w;
  logic [4*NDIG-1:0] bcd_s;
  logic              run_w, run_s;
  logic              pau_w, pau_s;
  logic              ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  bcd_stopwatch_ctrl #(.NDIG(NDIG), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .bcd_out(bcd_w), .running(run_w),
    .paused(pau_w), .ovf(ovf_w)
  );

  bcd_stopwatch_ctrl #(.NDIG(NDIG), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .bcd_out(bcd_s), .running(run_s),
    .paused(pau_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] lap_exp;
    rst = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    #22;
    check("rst_bcd", 32'(bcd_w), 32'h0);
    check("rst_run", 32'(run_w), 32'h0);
    check("rst_pau", 32'(pau_w), 32'h0);
    check("rst_ovf", 32'(ovf_w), 32'h0);
    rst = 1'b1;

    // Reset asserted mid-run takes effect immediately.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_run", 32'(run_w), 32'h1);
    ticks(37);
    check("cnt37", 32'(bcd_w), 32'h0037);
    #2;
    rst = 1'b0;
    #1;
    check("async_bcd", 32'(bcd_w), 32'h0);
    check("async_run", 32'(run_w), 32'h0);
    check("async_ovf", 32'(ovf_w), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_tick_ign", 32'(bcd_w), 32'h0);
    check("idle_after_rst", 32'(run_w), 32'h0);

    // start_stop with tick in IDLE: enters RUN, tick not counted.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_ss_tick_run", 32'(run_w), 32'h1);
    check("idle_ss_tick_bcd", 32'(bcd_w), 32'h0);

    // Carry across three digits on a single edge.
    ticks(1099);
    check("cnt1099", 32'(bcd_w), 32'h1099);
    ticks(1);
    check("cnt1100", 32'(bcd_w), 32'h1100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_bcd", 32'(bcd_w), 32'h0);
    check("clr_run", 32'(run_w), 32'h0);

    // Pause / resume.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    check("pr_5", 32'(bcd_w), 32'h0005);
    check("pr_pau0", 32'(pau_w), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("pr_pau1", 32'(pau_w), 32'h1);
    check("pr_run0", 32'(run_w), 32'h0);
    ticks(10);
    check("pr_hold", 32'(bcd_w), 32'h0005);
    check("pr_pau_gap", 32'(pau_w), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("pr_resume", 32'(run_w), 32'h1);
    check("pr_pau_off", 32'(pau_w), 32'h0);
    ticks(3);
    check("pr_8", 32'(bcd_w), 32'h0008);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_ss_cnt", 32'(bcd_w), 32'h0009);
    check("tick_ss_pau", 32'(pau_w), 32'h1);

    // clear beats start_stop from PAUSE.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("clrpri_bcd", 32'(bcd_w), 32'h0);
    check("clrpri_run", 32'(run_w), 32'h0);
    check("clrpri_pau", 32'(pau_w), 32'h0);

    // tick with clear in RUN: tick discarded.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("tickclr_bcd", 32'(bcd_w), 32'h0);
    check("tickclr_run", 32'(run_w), 32'h0);

    // Overflow: wrapping and saturating instances side by side.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(9999);
    check("pre_w", 32'(bcd_w), 32'h9999);
    check("pre_s", 32'(bcd_s), 32'h9999);
    check("pre_ovf", 32'(ovf_w), 32'h0);
    ticks(1);
    check("wrap_bcd", 32'(bcd_w), 32'h0000);
    check("wrap_ovf", 32'(ovf_w), 32'h1);
    check("wrap_run", 32'(run_w), 32'h1);
    check("sat_bcd", 32'(bcd_s), 32'h9999);
    check("sat_ovf", 32'(ovf_s), 32'h1);
    check("sat_run", 32'(run_s), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_ovf_pulse", 32'(ovf_w), 32'h0);
    check("wrap_bcd_hold", 32'(bcd_w), 32'h0000);
    check("sat_ovf_hold", 32'(ovf_s), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("halt_ss_run", 32'(run_s), 32'h0);
    check("halt_ss_pau", 32'(pau_s), 32'h0);
    check("halt_ss_bcd", 32'(bcd_s), 32'h9999);
    check("halt_ss_ovf", 32'(ovf_s), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_clr_bcd", 32'(bcd_s), 32'h0);
    check("halt_clr_ovf", 32'(ovf_s), 32'h0);
    check("halt_clr_w", 32'(bcd_w), 32'h0);

    // Lap freeze (display-only, internal count keeps running).
`ifdef STOPWATCH_LAP_EN
    lap_exp = 16'h0012;
`else
    lap_exp = 16'h0042;
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(12);
    check("lap_12", 32'(bcd_w), 32'h0012);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(30);
    check("lap_frozen", 32'(bcd_w), 32'(lap_exp));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", 32'(bcd_w), 32'h0042);
    ticks(1);
    check("lap_live", 32'(bcd_w), 32'h0043);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Sequencing controller for a chain of cascaded mod-10 (BCD decade) counters, forming a start/stop/clear stopwatch. A small state machine gates an external timebase tick into an NDIG-digit decade chain. It handles digit-to-digit carry, overflow (wrap or saturate) and an optional lap-freeze display. It sits between the debounced button pulses / timebase divider and the seven-segment display driver.

## Interface
- NDIG, 4, number of BCD digits in the chain (1..8); digit 0 is least significant.
- WRAP, 1, 1 = all-9s rolls over to all-0s and keeps running; 0 = saturate at all-9s and halt.

- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- tick  input  1  timebase enable; one-cycle pulse, one count per pulse.
- start_stop  input  1  one-cycle pulse; toggles run/pause.
- clear  input  1  one-cycle pulse; zero the count and return to idle.
- lap  input  1  one-cycle pulse; display freeze toggle (only with STOPWATCH_LAP_EN).
- bcd_out  output  4*NDIG  displayed count; digit i is bits [4i+3:4i].
- running  output  1  high in RUN.
- paused  output  1  high in PAUSE.
- ovf  output  1  overflow indication (see Operation).

## Operation
- States: IDLE, RUN, PAUSE, HALT (HALT is reachable only when WRAP=0).
- Reset (rst low, async): state IDLE, count 0, lap latch cleared, bcd_out=0, running=0, paused=0, ovf=0.
- Transitions, evaluated each rising edge; clear has priority over start_stop:
  - IDLE: start_stop -> RUN. Tick ignored.
  - RUN: clear -> IDLE (count 0); start_stop -> PAUSE.
  - PAUSE: clear -> IDLE (count 0); start_stop -> RUN. Tick ignored.
  - HALT: clear -> IDLE (count 0); all other inputs ignored.
- Counting occurs only in RUN with tick=1.
  - In that cycle digit 0 advances.
  - Digit i (i>0) advances only when every lower digit equals 9.
- Digit advance rule: a value of 9 or greater loads 0; otherwise it loads value+1. Illegal codes 10..15 therefore recover to 0 on their next advance.
- Overflow: RUN, tick=1, all digits 9.
  - WRAP=1: count becomes all 0, state stays RUN, ovf pulses high for exactly one cycle.
  - WRAP=0: count holds all 9s, state goes to HALT, ovf stays high until clear or reset.
- Simultaneous tick and start_stop in RUN: the tick is counted, then the state moves to PAUSE.
- Simultaneous tick and clear: the count goes to 0 and the tick is discarded.
- start_stop in IDLE together with tick: the state enters RUN and the tick is not counted.

## Timing
- All outputs are registered.
- bcd_out, running and paused reflect the edge at which the inputs were sampled: visible in the cycle after the pulse.
- Count latency: one cycle from tick sampled high to bcd_out updated (unfrozen display).
- The carry chain is combinational within one cycle. There is no ripple delay between digits, so every affected digit updates on the same edge.
- Pulse inputs are assumed single-cycle. If a pulse is held high for N cycles it acts as N pulses; start_stop therefore toggles every cycle.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap pulse in RUN captures the live count into a display register and sets the freeze latch.
  - While frozen, bcd_out shows the captured value and the internal count continues.
  - A second lap pulse in RUN or PAUSE releases the freeze: bcd_out shows the live count again from the next cycle.
  - clear or reset also releases the freeze.
  - lap in IDLE or HALT is ignored.
- STOPWATCH_LAP_EN undefined: the lap input is unused, there is no capture register, and bcd_out always shows the live count.

## Test plan
- Reset mid-run: start, 37 ticks, assert rst low between clock edges -> bcd_out=0000 immediately, running=0, ovf=0; IDLE after release.
- Carry: start, 1099 ticks (NDIG=4) -> bcd_out=1099; next tick -> 1100 with digits 0, 1 and 2 updating on the same edge.
- Pause/resume: start, 5 ticks, start_stop, 10 ticks, start_stop, 3 ticks -> bcd_out=0008, paused high only during the gap; tick coincident with start_stop in RUN is counted.
- Overflow: preload via 9999 ticks, then one more tick.
  - WRAP=1 -> 0000, ovf high exactly one cycle, running=1.
  - WRAP=0 -> 9999, HALT, ovf held high; start_stop ignored; clear -> 0000, ovf=0.
- Clear priority: clear and start_stop in the same cycle from PAUSE -> IDLE, count 0000.
- Lap (macro defined): start, 12 ticks, lap, 30 ticks -> bcd_out=0012 while internal count is 42; lap -> bcd_out=0042 next cycle. Macro undefined: same stimulus -> bcd_out=0042 throughout.
